multicycle_control_unit: RTL and testbench

- FSM-sequenced control unit for the multicycle MIPS datapath; successor to the single-cycle combinational control decode.
- Latches the fetched word into an internal instruction register (IR) and steps each instruction through FETCH, DECODE, EXEC, MEM and WB, waiting on cache ihit/dhit.
- Drives the request/enable strobes for the register file, ALU, PC and request unit.
- Adds parametrised memory-wait watchdog, overflow trap and illegal-opcode trap; all traps end in a sticky HALT.

---
 rtl/multicycle_control_unit_if.sv | 53 +++++
 rtl/multicycle_control_unit.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// Module  : multicycle_control_unit_if
// Brief   : Control-unit <-> datapath/cache signal bundle.
// Rev     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_unit_if;
    logic [31:0] instr;
    logic        ihit;
    logic        dhit;
    logic        zero_f;
    logic        overflow_f;

    logic        iren;
    logic        dren;
    logic        dwen;
    logic        ir_wen;
    logic        pc_wen;
    logic [1:0]  pc_src;
    logic        reg_wen;
    logic [4:0]  wsel;
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src;
    logic        ext_op;
    logic [1:0]  w_mux;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic [25:0] j_addr26;
    logic        halt;
    logic        mem_err;
    logic        ovf_exc;
    logic        ill_exc;
    logic [2:0]  state_o;

    modport master (
        input  instr, ihit, dhit, zero_f, overflow_f,
        output iren, dren, dwen, ir_wen, pc_wen, pc_src, reg_wen,
               wsel, rsel1, rsel2, alu_op, alu_src, ext_op, w_mux,
               imm16, shamt, j_addr26, halt, mem_err, ovf_exc, ill_exc, state_o
    );

    modport slave (
        output instr, ihit, dhit, zero_f, overflow_f,
        input  iren, dren, dwen, ir_wen, pc_wen, pc_src, reg_wen,
               wsel, rsel1, rsel2, alu_op, alu_src, ext_op, w_mux,
               imm16, shamt, j_addr26, halt, mem_err, ovf_exc, ill_exc, state_o
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// Module  : multicycle_control_unit
// Brief   : FSM control for the multicycle MIPS datapath with traps/watchdog.
// Rev     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit #(
    parameter int WAIT_LIMIT = 0,
    parameter int OVF_TRAP   = 1,
    parameter int ILL_TRAP   = 1
) (
    input  logic                        CLK,
    input  logic                        nRST,
    multicycle_control_unit_if.master   bus
);

    localparam logic [2:0] c_fetch  = 3'd0;
    localparam logic [2:0] c_decode = 3'd1;
    localparam logic [2:0] c_exec   = 3'd2;
    localparam logic [2:0] c_mem    = 3'd3;
    localparam logic [2:0] c_wb     = 3'd4;
    localparam logic [2:0] c_halt   = 3'd5;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_addiu = 6'h09;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_sltiu = 6'h0B;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_xori  = 6'h0E;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_halt  = 6'h3F;

    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_xor  = 6'h26;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2A;
    localparam logic [5:0] c_fn_sltu = 6'h2B;

    localparam logic [3:0] c_alu_sll  = 4'd0;
    localparam logic [3:0] c_alu_srl  = 4'd1;
    localparam logic [3:0] c_alu_add  = 4'd2;
    localparam logic [3:0] c_alu_sub  = 4'd3;
    localparam logic [3:0] c_alu_and  = 4'd4;
    localparam logic [3:0] c_alu_or   = 4'd5;
    localparam logic [3:0] c_alu_xor  = 4'd6;
    localparam logic [3:0] c_alu_nor  = 4'd7;
    localparam logic [3:0] c_alu_slt  = 4'd8;
    localparam logic [3:0] c_alu_sltu = 4'd9;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [31:0] r_ir;
    logic        r_mem_err;
    logic        r_ovf_exc;
    logic        r_ill_exc;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_legal;
    logic        w_is_halt;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_j;
    logic        w_is_jal;
    logic        w_is_jr;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_ovf_op;
    logic [3:0]  w_alu_op;
    logic [1:0]  w_alu_src;
    logic        w_ext_op;
    logic [1:0]  w_wmux;
    logic [4:0]  w_wsel;
    logic        w_ovf_trap;
    logic        w_timeout;

    assign w_op    = r_ir[31:26];
    assign w_funct = r_ir[5:0];

    // Instruction decode from the IR; data-path selects are valid in every state
    always_comb begin
        w_legal   = 1'b1;
        w_is_halt = 1'b0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_j    = 1'b0;
        w_is_jal  = 1'b0;
        w_is_jr   = 1'b0;
        w_is_lw   = 1'b0;
        w_is_sw   = 1'b0;
        w_ovf_op  = 1'b0;
        w_alu_op  = c_alu_add;
        w_alu_src = 2'd1;
        w_ext_op  = 1'b1;
        w_wmux    = 2'd0;
        w_wsel    = r_ir[20:16];
        case (w_op)
            c_op_rtype: begin
                w_wsel    = r_ir[15:11];
                w_alu_src = 2'd0;
                case (w_funct)
                    c_fn_sll:  begin w_alu_op = c_alu_sll; w_alu_src = 2'd2; end
                    c_fn_srl:  begin w_alu_op = c_alu_srl; w_alu_src = 2'd2; end
                    c_fn_jr:   w_is_jr = 1'b1;
                    c_fn_add:  begin w_alu_op = c_alu_add; w_ovf_op = 1'b1; end
                    c_fn_addu: w_alu_op = c_alu_add;
                    c_fn_sub:  begin w_alu_op = c_alu_sub; w_ovf_op = 1'b1; end
                    c_fn_subu: w_alu_op = c_alu_sub;
                    c_fn_and:  w_alu_op = c_alu_and;
                    c_fn_or:   w_alu_op = c_alu_or;
                    c_fn_xor:  w_alu_op = c_alu_xor;
                    c_fn_nor:  w_alu_op = c_alu_nor;
                    c_fn_slt:  w_alu_op = c_alu_slt;
                    c_fn_sltu: w_alu_op = c_alu_sltu;
                    default:   w_legal = 1'b0;
                endcase
            end
            c_op_beq:   begin w_is_beq = 1'b1; w_alu_op = c_alu_sub; w_alu_src = 2'd0; end
            c_op_bne:   begin w_is_bne = 1'b1; w_alu_op = c_alu_sub; w_alu_src = 2'd0; end
            c_op_addi:  begin w_alu_op = c_alu_add; w_ovf_op = 1'b1; end
            c_op_addiu: w_alu_op = c_alu_add;
            c_op_slti:  w_alu_op = c_alu_slt;
            c_op_sltiu: w_alu_op = c_alu_sltu;
            c_op_andi:  begin w_alu_op = c_alu_and; w_ext_op = 1'b0; end
            c_op_ori:   begin w_alu_op = c_alu_or;  w_ext_op = 1'b0; end
            c_op_xori:  begin w_alu_op = c_alu_xor; w_ext_op = 1'b0; end
            c_op_lui:   begin w_wmux = 2'd3; w_ext_op = 1'b0; end
            c_op_lw:    begin w_is_lw = 1'b1; w_wmux = 2'd1; end
            c_op_sw:    w_is_sw = 1'b1;
            c_op_j:     w_is_j = 1'b1;
            c_op_jal:   begin w_is_jal = 1'b1; w_wsel = 5'd31; w_wmux = 2'd2; end
            c_op_halt:  w_is_halt = 1'b1;
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_ovf_trap = (OVF_TRAP != 0) && w_ovf_op && bus.overflow_f;

    generate
        if (WAIT_LIMIT > 0) begin : g_wd
            localparam int c_cw = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
            logic [c_cw-1:0] r_wait_cnt;
            logic            w_waiting;
            logic            w_hit;

            assign w_waiting = (r_state == c_fetch) || (r_state == c_mem);
            assign w_hit     = (r_state == c_fetch) ? bus.ihit : bus.dhit;
            // Fires on the cycle whose increment would reach the limit; a hit still wins
            assign w_timeout = w_waiting && !w_hit &&
                               (r_wait_cnt == c_cw'(WAIT_LIMIT - 1));

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_wait_cnt <= '0;
                end else if (w_waiting && !w_hit && !w_timeout) begin
                    r_wait_cnt <= r_wait_cnt + c_cw'(1);
                end else begin
                    r_wait_cnt <= '0;
                end
            end
        end else begin : g_no_wd
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= c_fetch;
            r_ir      <= '0;
            r_mem_err <= 1'b0;
            r_ovf_exc <= 1'b0;
            r_ill_exc <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == c_fetch) && bus.ihit) begin
                r_ir <= bus.instr;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
            if ((r_state == c_exec) && w_ovf_trap) begin
                r_ovf_exc <= 1'b1;
            end
            if ((r_state == c_decode) && !w_is_halt && !w_legal && (ILL_TRAP != 0)) begin
                r_ill_exc <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_fetch: begin
                if (bus.ihit)       w_state_next = c_decode;
                else if (w_timeout) w_state_next = c_halt;
            end
            c_decode: begin
                if (w_is_halt)      w_state_next = c_halt;
                else if (!w_legal)  w_state_next = (ILL_TRAP != 0) ? c_halt : c_fetch;
                else                w_state_next = c_exec;
            end
            c_exec: begin
                if (w_ovf_trap)                                  w_state_next = c_halt;
                else if (w_is_beq || w_is_bne || w_is_j || w_is_jr) w_state_next = c_fetch;
                else if (w_is_lw || w_is_sw)                     w_state_next = c_mem;
                else                                             w_state_next = c_wb;
            end
            c_mem: begin
                if (bus.dhit)       w_state_next = w_is_lw ? c_wb : c_fetch;
                else if (w_timeout) w_state_next = c_halt;
            end
            c_wb:    w_state_next = c_fetch;
            c_halt:  w_state_next = c_halt;
            default: w_state_next = c_fetch;
        endcase
    end

    always_comb begin
        bus.iren    = 1'b0;
        bus.dren    = 1'b0;
        bus.dwen    = 1'b0;
        bus.ir_wen  = 1'b0;
        bus.pc_wen  = 1'b0;
        bus.pc_src  = 2'd0;
        bus.reg_wen = 1'b0;
        bus.halt    = 1'b0;
        case (r_state)
            c_fetch: begin
                bus.iren = 1'b1;
                if (bus.ihit) begin
                    bus.ir_wen = 1'b1;
                    bus.pc_wen = 1'b1;
                end
            end
            c_exec: begin
                if (w_is_beq || w_is_bne) begin
                    bus.pc_wen = bus.zero_f ~^ w_is_beq;
                    bus.pc_src = 2'd1;
                end else if (w_is_j || w_is_jal) begin
                    bus.pc_wen = 1'b1;
                    bus.pc_src = 2'd2;
                end else if (w_is_jr) begin
                    bus.pc_wen = 1'b1;
                    bus.pc_src = 2'd3;
                end
            end
            c_mem: begin
                bus.dren = w_is_lw;
                bus.dwen = w_is_sw;
            end
            c_wb:    bus.reg_wen = 1'b1;
            c_halt:  bus.halt    = 1'b1;
            default: ;
        endcase
    end

    assign bus.wsel     = w_wsel;
    assign bus.rsel1    = r_ir[25:21];
    assign bus.rsel2    = r_ir[20:16];
    assign bus.alu_op   = w_alu_op;
    assign bus.alu_src  = w_alu_src;
    assign bus.ext_op   = w_ext_op;
    assign bus.w_mux    = w_wmux;
    assign bus.imm16    = r_ir[15:0];
    assign bus.shamt    = r_ir[10:6];
    assign bus.j_addr26 = r_ir[25:0];
    assign bus.mem_err  = r_mem_err;
    assign bus.ovf_exc  = r_ovf_exc;
    assign bus.ill_exc  = r_ill_exc;
    assign bus.state_o  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// Module  : tb_multicycle_control_unit
// Brief   : Directed vector table plus multi-cycle sequences for the control unit.
// Rev     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_unit;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5;

    // strobe order: {iren, dren, dwen, ir_wen, pc_wen}
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_IF   = 5'b10000;
    localparam logic [4:0] S_FH   = 5'b10011;
    localparam logic [4:0] S_PC   = 5'b00001;
    localparam logic [4:0] S_DW   = 5'b00100;

    localparam logic [31:0] ADDU  = 32'h0022_1821;
    localparam logic [31:0] ADD   = 32'h0022_1820;
    localparam logic [31:0] LW    = 32'h8CC5_0004;
    localparam logic [31:0] SW    = 32'hACC5_0008;
    localparam logic [31:0] BEQ   = 32'h1022_0003;
    localparam logic [31:0] BNE   = 32'h1422_0003;
    localparam logic [31:0] JAL   = 32'h0C10_0000;
    localparam logic [31:0] HALTI = 32'hFC00_0000;
    localparam logic [31:0] ILL   = 32'hF800_0000;

    typedef struct {
        logic        rn;
        logic [31:0] ins;
        logic        ih, dh, zf, of;
        logic [2:0]  st;
        logic [4:0]  strb;
        logic [1:0]  psrc;
        logic        rw;
        logic [4:0]  ws;
        logic [1:0]  wm;
        logic [3:0]  fl;   // {halt, mem_err, ovf_exc, ill_exc}
    } vec_t;

    logic clk;
    logic nRST;
    int   n_checks;
    int   n_fail;
    vec_t vt[$];

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(
        .WAIT_LIMIT (4),
        .OVF_TRAP   (1),
        .ILL_TRAP   (1)
    ) dut (
        .CLK  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rn, input logic [31:0] ins,
                                input logic ih, input logic dh, input logic zf, input logic of,
                                input logic [2:0] st, input logic [4:0] strb, input logic [1:0] psrc,
                                input logic rw, input logic [4:0] ws, input logic [1:0] wm,
                                input logic [3:0] fl);
        vec_t v;
        v.rn = rn; v.ins = ins; v.ih = ih; v.dh = dh; v.zf = zf; v.of = of;
        v.st = st; v.strb = strb; v.psrc = psrc; v.rw = rw; v.ws = ws; v.wm = wm; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic [31:0] ins,
                         input logic ih, input logic dh, input logic zf, input logic of);
        @(negedge clk);
        nRST           = rn;
        bus.instr      = ins;
        bus.ihit       = ih;
        bus.dhit       = dh;
        bus.zero_f     = zf;
        bus.overflow_f = of;
        #1;
    endtask

    function automatic logic [4:0] strobes();
        return {bus.iren, bus.dren, bus.dwen, bus.ir_wen, bus.pc_wen};
    endfunction

    function automatic logic [3:0] flags();
        return {bus.halt, bus.mem_err, bus.ovf_exc, bus.ill_exc};
    endfunction

    initial begin
        int dren_cnt;
        int iren_cnt;
        n_checks = 0;
        n_fail   = 0;
        nRST = 1'b0;
        bus.instr = '0; bus.ihit = 1'b0; bus.dhit = 1'b0;
        bus.zero_f = 1'b0; bus.overflow_f = 1'b0;

        // reset, then ADDU with ihit on the second FETCH cycle
        vt.push_back(mk(0, 0,    0,0,0,0, F, S_IF,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, 0,    0,0,0,0, F, S_IF,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADDU, 1,0,0,0, F, S_FH,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADDU, 0,0,0,0, D, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADDU, 0,0,0,0, E, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADDU, 0,0,0,0, W, S_NONE, 0, 1, 3, 0, 4'b0000));
        // BEQ taken, BNE not taken with zero_f = 1
        vt.push_back(mk(1, BEQ,  1,0,0,0, F, S_FH,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, BEQ,  0,0,0,0, D, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, BEQ,  0,0,1,0, E, S_PC,   1, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, BNE,  1,0,0,0, F, S_FH,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, BNE,  0,0,0,0, D, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, BNE,  0,0,1,0, E, S_NONE, 0, 0, 0, 0, 4'b0000));
        // JAL: jump in EXEC, link write to r31
        vt.push_back(mk(1, JAL,  1,0,0,0, F, S_FH,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, JAL,  0,0,0,0, D, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, JAL,  0,0,0,0, E, S_PC,   2, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, JAL,  0,0,0,0, W, S_NONE, 0, 1, 31, 2, 4'b0000));
        // SW: dwen held until dhit, then straight to FETCH
        vt.push_back(mk(1, SW,   1,0,0,0, F, S_FH,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, SW,   0,0,0,0, D, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, SW,   0,0,0,0, E, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, SW,   0,0,0,0, M, S_DW,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, SW,   0,1,0,0, M, S_DW,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, SW,   0,0,0,0, F, S_IF,   0, 0, 0, 0, 4'b0000));
        // ADD overflow trap; hits in HALT are ignored
        vt.push_back(mk(1, ADD,  1,0,0,0, F, S_FH,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADD,  0,0,0,0, D, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADD,  0,0,0,1, E, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADD,  0,0,0,0, H, S_NONE, 0, 0, 0, 0, 4'b1010));
        vt.push_back(mk(1, ADD,  1,1,0,0, H, S_NONE, 0, 0, 0, 0, 4'b1010));
        // HALT opcode: halt without cause flags
        vt.push_back(mk(0, 0,    0,0,0,0, F, S_IF,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, HALTI,1,0,0,0, F, S_FH,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, HALTI,0,0,0,0, D, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, HALTI,0,0,0,0, H, S_NONE, 0, 0, 0, 0, 4'b1000));
        // illegal opcode 0x3E
        vt.push_back(mk(0, 0,    0,0,0,0, F, S_IF,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ILL,  1,0,0,0, F, S_FH,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ILL,  0,0,0,0, D, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ILL,  0,0,0,0, H, S_NONE, 0, 0, 0, 0, 4'b1001));
        // ADDU ignores the overflow flag
        vt.push_back(mk(0, 0,    0,0,0,0, F, S_IF,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADDU, 1,0,0,0, F, S_FH,   0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADDU, 0,0,0,0, D, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADDU, 0,0,0,1, E, S_NONE, 0, 0, 0, 0, 4'b0000));
        vt.push_back(mk(1, ADDU, 0,0,0,0, W, S_NONE, 0, 1, 3, 0, 4'b0000));
        vt.push_back(mk(1, ADDU, 0,0,0,0, F, S_IF,   0, 0, 0, 0, 4'b0000));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rn, vt[i].ins, vt[i].ih, vt[i].dh, vt[i].zf, vt[i].of);
            chk($sformatf("v%0d.state", i),   32'(bus.state_o), 32'(vt[i].st));
            chk($sformatf("v%0d.strobes", i), 32'(strobes()),   32'(vt[i].strb));
            chk($sformatf("v%0d.reg_wen", i), 32'(bus.reg_wen), 32'(vt[i].rw));
            chk($sformatf("v%0d.flags", i),   32'(flags()),     32'(vt[i].fl));
            if (vt[i].strb[0]) chk($sformatf("v%0d.pc_src", i), 32'(bus.pc_src), 32'(vt[i].psrc));
            if (vt[i].rw) begin
                chk($sformatf("v%0d.wsel", i),  32'(bus.wsel),  32'(vt[i].ws));
                chk($sformatf("v%0d.w_mux", i), 32'(bus.w_mux), 32'(vt[i].wm));
            end
        end

        // LW with dhit on the third MEM cycle
        drive(0, 0, 0, 0, 0, 0);
        drive(1, LW, 1, 0, 0, 0);
        drive(1, LW, 0, 0, 0, 0);
        drive(1, LW, 0, 0, 0, 0);
        chk("lw.exec", 32'(bus.state_o), 32'(E));
        dren_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, LW, 0, (i == 2), 0, 0);
            if (bus.dren && bus.state_o == M) dren_cnt++;
        end
        chk("lw.dren_cycles", 32'(dren_cnt), 32'd3);
        drive(1, LW, 0, 0, 0, 0);
        chk("lw.wb_state", 32'(bus.state_o), 32'(W));
        chk("lw.wb_regwen", 32'(bus.reg_wen), 32'd1);
        chk("lw.wb_dren",   32'(bus.dren),    32'd0);
        chk("lw.wsel",      32'(bus.wsel),    32'd5);
        chk("lw.w_mux",     32'(bus.w_mux),   32'd1);
        chk("lw.ext_op",    32'(bus.ext_op),  32'd1);
        chk("lw.alu_src",   32'(bus.alu_src), 32'd1);
        chk("lw.imm16",     32'(bus.imm16),   32'h0004);
        chk("lw.rsel1",     32'(bus.rsel1),   32'd6);
        drive(1, LW, 0, 0, 0, 0);
        chk("lw.back_fetch", 32'(bus.state_o), 32'(F));

        // hit arriving on the limit cycle is honoured
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);
        drive(1, ADDU, 1, 0, 0, 0);
        chk("wd_hit.ir_wen", 32'(bus.ir_wen), 32'd1);
        drive(1, ADDU, 0, 0, 0, 0);
        chk("wd_hit.state", 32'(bus.state_o), 32'(D));
        chk("wd_hit.mem_err", 32'(bus.mem_err), 32'd0);

        // fetch watchdog: no ihit at all
        drive(0, 0, 0, 0, 0, 0);
        iren_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            if (bus.iren) iren_cnt++;
        end
        chk("wd.iren_cycles", 32'(iren_cnt), 32'd4);
        chk("wd.state", 32'(bus.state_o), 32'(H));
        chk("wd.flags", 32'(flags()), 32'b1100);
        drive(1, ADDU, 1, 1, 1, 1);
        chk("wd.strobes_halt", 32'({strobes(), bus.reg_wen}), 32'd0);
        chk("wd.sticky", 32'(flags()), 32'b1100);
        drive(0, 0, 0, 0, 0, 0);
        chk("wd.reset_state", 32'(bus.state_o), 32'(F));
        chk("wd.reset_flags", 32'(flags()), 32'd0);
        chk("wd.reset_iren", 32'(bus.iren), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
